dlsc_axi_router_wr_ooo: RTL



---
 rtl/dlsc_axi_router_wr_ooo_pkg.sv | 13 +
 rtl/dlsc_axi_router_wr_fifo.sv | 55 +++++
 rtl/dlsc_axi_router_wr_ooo.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dlsc_axi_router_wr_ooo_pkg.sv
// Shared constants and helpers for the dlsc AXI write router.
// Imported by the router top and its FIFO.
package dlsc_axi_router_wr_ooo_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Index width that stays legal for a single-entry range
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dlsc_axi_router_wr_fifo.sv
// Synchronous FIFO with full/empty flags and a combinational head.
// Pushes while full and pops while empty are ignored.
module dlsc_axi_router_wr_fifo
    import dlsc_axi_router_wr_ooo_pkg::*;
#(
    parameter int DATA  = 8,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [DATA-1:0] wr_data,
    input  logic            pop,
    output logic [DATA-1:0] rd_data,
    output logic            full,
    output logic            empty
);

    localparam int AB = idx_bits(DEPTH);
    localparam logic [AB:0] FULL_CNT = DEPTH[AB:0];

    logic [DATA-1:0] mem [DEPTH];
    logic [AB-1:0]   wr_ptr;
    logic [AB-1:0]   rd_ptr;
    logic [AB:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dlsc_axi_router_wr_ooo.sv
// AXI write router: INPUTS masters to OUTPUTS slaves plus a DECERR target.
// One AW slot; W follows the AW order; B returns per output in AW order.
module dlsc_axi_router_wr_ooo
    import dlsc_axi_router_wr_ooo_pkg::*;
#(
    parameter int ADDR    = 32,
    parameter int DATA    = 32,
    parameter int LEN     = 4,
    parameter int INPUTS  = 2,
    parameter int OUTPUTS = 2,
    parameter int MOT     = 16,
    parameter bit ARB_RR  = 1'b1,
    parameter bit DECERR  = 1'b1,
    parameter logic [OUTPUTS*ADDR-1:0] MASKS = '0,
    parameter logic [OUTPUTS*ADDR-1:0] BASES = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [INPUTS-1:0]           in_aw_ready,
    input  logic [INPUTS-1:0]           in_aw_valid,
    input  logic [INPUTS*ADDR-1:0]      in_aw_addr,
    input  logic [INPUTS*LEN-1:0]       in_aw_len,
    output logic [INPUTS-1:0]           in_w_ready,
    input  logic [INPUTS-1:0]           in_w_valid,
    input  logic [INPUTS-1:0]           in_w_last,
    input  logic [INPUTS*DATA-1:0]      in_w_data,
    input  logic [INPUTS*(DATA/8)-1:0]  in_w_strb,
    input  logic [INPUTS-1:0]           in_b_ready,
    output logic [INPUTS-1:0]           in_b_valid,
    output logic [INPUTS*2-1:0]         in_b_resp,
    input  logic [OUTPUTS-1:0]          out_aw_ready,
    output logic [OUTPUTS-1:0]          out_aw_valid,
    output logic [OUTPUTS*ADDR-1:0]     out_aw_addr,
    output logic [OUTPUTS*LEN-1:0]      out_aw_len,
    input  logic [OUTPUTS-1:0]          out_w_ready,
    output logic [OUTPUTS-1:0]          out_w_valid,
    output logic [OUTPUTS-1:0]          out_w_last,
    output logic [OUTPUTS*DATA-1:0]     out_w_data,
    output logic [OUTPUTS*(DATA/8)-1:0] out_w_strb,
    output logic [OUTPUTS-1:0]          out_b_ready,
    input  logic [OUTPUTS-1:0]          out_b_valid,
    input  logic [OUTPUTS*2-1:0]        out_b_resp
);

    localparam int STRB     = DATA / 8;
    localparam int INPUTSB  = idx_bits(INPUTS);
    localparam int OUTPUTSB = $clog2(OUTPUTS + 1);
    localparam int MOTB     = $clog2(MOT);
    localparam int WOB      = INPUTSB + OUTPUTSB;
    localparam logic [OUTPUTSB-1:0] ERR_T = OUTPUTSB'(OUTPUTS);

    logic [OUTPUTSB-1:0] dec [INPUTS];
    logic [INPUTSB-1:0]  rr_ptr;
    logic [INPUTSB-1:0]  grant;
    logic                grant_vld;
    logic [OUTPUTSB-1:0] gtgt;
    logic                aw_ok;
    int                  idx;

    logic                slot_valid;
    logic [ADDR-1:0]     slot_addr;
    logic [LEN-1:0]      slot_len;
    logic [OUTPUTSB-1:0] slot_tgt;

    logic [WOB-1:0]      wo_head;
    logic [INPUTSB-1:0]  wo_src;
    logic [OUTPUTSB-1:0] wo_dst;
    logic                wo_full;
    logic                wo_empty;
    logic                w_pop;

    logic [INPUTSB-1:0]  b_head [OUTPUTS+1];
    logic [OUTPUTS:0]    b_full;
    logic [OUTPUTS:0]    b_empty;
    logic [OUTPUTS:0]    b_pop;
    logic [INPUTS-1:0]   taken;

    logic [MOTB:0]       err_cnt;
    logic                err_inc;
    logic                err_dec;

    // Lowest matching window wins; unmatched goes to the error target or 0
    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            dec[i] = DECERR ? ERR_T : '0;
            for (int j = OUTPUTS - 1; j >= 0; j--) begin
                if ((in_aw_addr[i*ADDR +: ADDR] & MASKS[j*ADDR +: ADDR])
                    == BASES[j*ADDR +: ADDR])
                    dec[i] = OUTPUTSB'(j);
            end
        end
    end

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < INPUTS; k++) begin
            idx = ARB_RR ? (int'(rr_ptr) + k) % INPUTS : k;
            if (!grant_vld && in_aw_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = INPUTSB'(idx);
            end
        end
    end

    assign gtgt  = dec[grant];
    assign aw_ok = !rst && !slot_valid && grant_vld
                   && !wo_full && !b_full[gtgt];

    always_comb begin
        in_aw_ready        = '0;
        in_aw_ready[grant] = aw_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot_addr  <= '0;
            slot_len   <= '0;
            slot_tgt   <= '0;
            rr_ptr     <= '0;
        end else if (aw_ok) begin
            slot_valid <= 1'b1;
            slot_addr  <= in_aw_addr[grant*ADDR +: ADDR];
            slot_len   <= in_aw_len[grant*LEN +: LEN];
            slot_tgt   <= gtgt;
            rr_ptr     <= (int'(grant) + 1 == INPUTS) ? '0 : grant + 1'b1;
        end else if (slot_valid &&
                     (slot_tgt == ERR_T || out_aw_ready[slot_tgt])) begin
            slot_valid <= 1'b0;
        end
    end

    always_comb begin
        out_aw_valid = '0;
        for (int o = 0; o < OUTPUTS; o++)
            out_aw_valid[o] = slot_valid && (slot_tgt == OUTPUTSB'(o));
    end

    assign out_aw_addr = {OUTPUTS{slot_addr}};
    assign out_aw_len  = {OUTPUTS{slot_len}};

    dlsc_axi_router_wr_fifo #(.DATA(WOB), .DEPTH(MOT)) u_wo (
        .clk     (clk),
        .rst     (rst),
        .push    (aw_ok),
        .wr_data ({grant, gtgt}),
        .pop     (w_pop),
        .rd_data (wo_head),
        .full    (wo_full),
        .empty   (wo_empty)
    );

    assign wo_src = wo_head[WOB-1 -: INPUTSB];
    assign wo_dst = wo_head[OUTPUTSB-1:0];

    always_comb begin
        in_w_ready  = '0;
        out_w_valid = '0;
        out_w_last  = '0;
        out_w_data  = '0;
        out_w_strb  = '0;
        w_pop       = 1'b0;
        if (!wo_empty) begin
            if (wo_dst == ERR_T) begin
                in_w_ready[wo_src] = 1'b1;
            end else begin
                for (int o = 0; o < OUTPUTS; o++) begin
                    if (wo_dst == OUTPUTSB'(o)) begin
                        out_w_valid[o] = in_w_valid[wo_src];
                        out_w_last[o]  = in_w_last[wo_src];
                        out_w_data[o*DATA +: DATA] = in_w_data[wo_src*DATA +: DATA];
                        out_w_strb[o*STRB +: STRB] = in_w_strb[wo_src*STRB +: STRB];
                        in_w_ready[wo_src] = out_w_ready[o];
                    end
                end
            end
            w_pop = in_w_valid[wo_src] && in_w_ready[wo_src] && in_w_last[wo_src];
        end
    end

    assign err_inc = w_pop && (wo_dst == ERR_T);

    for (genvar t = 0; t <= OUTPUTS; t++) begin : g_b
        dlsc_axi_router_wr_fifo #(.DATA(INPUTSB), .DEPTH(MOT)) u_b (
            .clk     (clk),
            .rst     (rst),
            .push    (aw_ok && (gtgt == OUTPUTSB'(t))),
            .wr_data (grant),
            .pop     (b_pop[t]),
            .rd_data (b_head[t]),
            .full    (b_full[t]),
            .empty   (b_empty[t])
        );
    end

    // Lower output index claims the input first; error target goes last
    always_comb begin
        in_b_valid  = '0;
        in_b_resp   = '0;
        out_b_ready = '0;
        b_pop       = '0;
        taken       = '0;
        err_dec     = 1'b0;
        for (int o = 0; o < OUTPUTS; o++) begin
            if (!b_empty[o] && !taken[b_head[o]]) begin
                out_b_ready[o] = in_b_ready[b_head[o]];
                if (out_b_valid[o]) begin
                    taken[b_head[o]]            = 1'b1;
                    in_b_valid[b_head[o]]       = 1'b1;
                    in_b_resp[b_head[o]*2 +: 2] = out_b_resp[o*2 +: 2];
                    b_pop[o]                    = out_b_ready[o];
                end
            end
        end
        if (err_cnt != '0 && !b_empty[OUTPUTS] && !taken[b_head[OUTPUTS]]) begin
            in_b_valid[b_head[OUTPUTS]]       = 1'b1;
            in_b_resp[b_head[OUTPUTS]*2 +: 2] = RESP_DECERR;
            err_dec                           = in_b_ready[b_head[OUTPUTS]];
            b_pop[OUTPUTS]                    = err_dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else begin
            unique case ({err_inc, err_dec})
                2'b10:   err_cnt <= err_cnt + 1'b1;
                2'b01:   err_cnt <= err_cnt - 1'b1;
                default: err_cnt <= err_cnt;
            endcase
        end
    end

endmodule
